// File: rtl/demux_stream_1ton.sv
// Registered 1-to-NUM_OUT stream demultiplexer with per-packet destination lock.
// Optional dropped-beat counter built when DEMUX_ERR_CNT_EN is defined.
module demux_stream_1ton #(
  parameter  int NUM_OUT = 8,
  parameter  int DATA_W  = 8,
  localparam int SEL_W   = $clog2(NUM_OUT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_last,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_last,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic               busy,
  output logic [15:0]        err_cnt
);

  // Handshake: a beat moves on a port in the cycle where its valid and ready are
  // both high at the rising edge; valid never drops and the beat never changes
  // while it waits for ready.

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   dest_q, dest_d;
  logic               hold_valid_q, hold_valid_d;
  logic [SEL_W-1:0]   hold_dest_q, hold_dest_d;
  logic [DATA_W-1:0]  hold_data_q, hold_data_d;
  logic               hold_last_q, hold_last_d;

  logic               accept;
  logic               drain;
  logic               dest_ok;
  logic [SEL_W-1:0]   route_dest;

  // The packet head routes on in_sel directly; later beats use the latched dest.
  assign route_dest = (state_q == IDLE) ? in_sel : dest_q;

  generate
    if ((1 << SEL_W) == NUM_OUT) begin : g_pow2
      assign dest_ok = 1'b1;
    end else begin : g_npow2
      localparam logic [SEL_W:0] NUM_OUT_L = (SEL_W+1)'(NUM_OUT);
      assign dest_ok = ({1'b0, route_dest} < NUM_OUT_L);
    end
  endgenerate

  assign out_valid = hold_valid_q ? (NUM_OUT'(1) << hold_dest_q) : '0;
  assign out_data  = hold_data_q;
  assign out_last  = hold_last_q;
  assign drain     = |(out_valid & out_ready);
  assign in_ready  = ~hold_valid_q | drain;
  assign accept    = in_valid & in_ready;
  assign busy      = (state_q == LOCKED);

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (!in_last) begin
            state_d = LOCKED;
            dest_d  = in_sel;
          end
        end
        LOCKED: begin
          if (in_last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Beats to a nonexistent channel are accepted but never loaded into the holding stage.
  always_comb begin
    hold_valid_d = hold_valid_q & ~drain;
    hold_dest_d  = hold_dest_q;
    hold_data_d  = hold_data_q;
    hold_last_d  = hold_last_q;
    if (accept && dest_ok) begin
      hold_valid_d = 1'b1;
      hold_dest_d  = route_dest;
      hold_data_d  = in_data;
      hold_last_d  = in_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      dest_q       <= '0;
      hold_valid_q <= 1'b0;
      hold_dest_q  <= '0;
      hold_data_q  <= '0;
      hold_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      dest_q       <= dest_d;
      hold_valid_q <= hold_valid_d;
      hold_dest_q  <= hold_dest_d;
      hold_data_q  <= hold_data_d;
      hold_last_q  <= hold_last_d;
    end
  end

`ifdef DEMUX_ERR_CNT_EN
  logic        drop;
  logic [15:0] err_cnt_q;

  assign drop = accept & ~dest_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (drop && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule
